// File: rtl/btb_pkg.sv
// Shared types, counter constants and PC field helpers for the 2-way branch target buffer.
package btb_pkg;

    localparam int unsigned PC_W = 32;
    localparam int unsigned CNT_W = 2;

    localparam logic [CNT_W-1:0] CNT_MIN     = 2'b00;
    localparam logic [CNT_W-1:0] CNT_MAX     = 2'b11;
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = 2'b01;

    // Tag is kept zero-extended to PC_W so the struct does not depend on NUM_SETS.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        logic [CNT_W-1:0] cnt;
    } btb_entry_t;

    function automatic logic [CNT_W-1:0] sat_cnt_next(input logic [CNT_W-1:0] cnt, input logic taken);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (taken && cnt != CNT_MAX) begin
            nxt = CNT_W'(cnt + 2'd1);
        end else if (!taken && cnt != CNT_MIN) begin
            nxt = CNT_W'(cnt - 2'd1);
        end
        return nxt;
    endfunction

    function automatic logic [PC_W-1:0] pc_idx(input logic [PC_W-1:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [PC_W-1:0] pc_tag(input logic [PC_W-1:0] pc, input int unsigned idx_w);
        return pc >> (idx_w + 32'd2);
    endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: NUM_SETS entries, two combinational tag-compare read ports, one write port.
module btb_way
    import btb_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned IDX_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [PC_W-1:0]  rd_tag,
    output logic             rd_hit,
    output logic [PC_W-1:0]  rd_target,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic [PC_W-1:0]  upd_tag,
    output logic             upd_hit,
    output logic             upd_valid,
    output logic [CNT_W-1:0] upd_cnt
);

    btb_entry_t entry_q [NUM_SETS];
    btb_entry_t entry_d [NUM_SETS];

    // Clear drops only valid bits and takes priority over a write.
    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                entry_d[i].valid = 1'b0;
            end
        end else if (we) begin
            entry_d[wr_idx] = wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        rd_hit    = entry_q[rd_idx].valid && (entry_q[rd_idx].tag == rd_tag);
        rd_target = entry_q[rd_idx].target;
        rd_cnt    = entry_q[rd_idx].cnt;
        upd_hit   = entry_q[upd_idx].valid && (entry_q[upd_idx].tag == upd_tag);
        upd_valid = entry_q[upd_idx].valid;
        upd_cnt   = entry_q[upd_idx].cnt;
    end

endmodule

// File: rtl/btb_2way.sv
// 2-way set-associative BTB with 2-bit counters and per-set LRU victim bit.
// Optional perf counters (hit_count, alloc_count) are built when BTB_PERF_EN is defined.
module btb_2way
    import btb_pkg::*;
#(
    parameter int unsigned      NUM_SETS    = 8,
    parameter logic [CNT_W-1:0] CNT_INIT_T  = CNT_WEAK_T,
    parameter logic [CNT_W-1:0] CNT_INIT_NT = CNT_WEAK_NT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_valid,
    output logic [PC_W-1:0] predicted_pc,
    output logic            predictedTaken,
    input  logic            flush,
    input  logic            btb_update,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    output logic [31:0]     hit_count,
    output logic [31:0]     alloc_count
);

    localparam int unsigned IDX_W = $clog2(NUM_SETS);

    logic [IDX_W-1:0] lu_idx, up_idx;
    logic [PC_W-1:0]  lu_tag, up_tag;
    logic [1:0]       rd_hit, upd_hit, upd_valid, we;
    logic [PC_W-1:0]  rd_target [2];
    logic [CNT_W-1:0] rd_cnt [2];
    logic [CNT_W-1:0] upd_cnt [2];
    logic             upd_hit_c, wr_way_c;
    btb_entry_t       wr_entry;
    logic [NUM_SETS-1:0] lru_q, lru_d;

    assign lu_idx = IDX_W'(pc_idx(lookup_pc, IDX_W));
    assign lu_tag = pc_tag(lookup_pc, IDX_W);
    assign up_idx = IDX_W'(pc_idx(upd_pc, IDX_W));
    assign up_tag = pc_tag(upd_pc, IDX_W);

    for (genvar w = 0; w < 2; w++) begin : g_way
        btb_way #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) u_way (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (flush),
            .we        (we[w]),
            .wr_idx    (up_idx),
            .wr_entry  (wr_entry),
            .rd_idx    (lu_idx),
            .rd_tag    (lu_tag),
            .rd_hit    (rd_hit[w]),
            .rd_target (rd_target[w]),
            .rd_cnt    (rd_cnt[w]),
            .upd_idx   (up_idx),
            .upd_tag   (up_tag),
            .upd_hit   (upd_hit[w]),
            .upd_valid (upd_valid[w]),
            .upd_cnt   (upd_cnt[w])
        );
    end

    // Lookup mux; way 0 wins if both ever match.
    always_comb begin
        pred_valid     = rd_hit[0] | rd_hit[1];
        predicted_pc   = '0;
        predictedTaken = 1'b0;
        if (rd_hit[0]) begin
            predicted_pc   = rd_target[0];
            predictedTaken = rd_cnt[0][1];
        end else if (rd_hit[1]) begin
            predicted_pc   = rd_target[1];
            predictedTaken = rd_cnt[1][1];
        end
    end

    // Write-way choice: hit way, else first invalid way, else LRU victim.
    always_comb begin
        upd_hit_c = upd_hit[0] | upd_hit[1];
        if (upd_hit[0])        wr_way_c = 1'b0;
        else if (upd_hit[1])   wr_way_c = 1'b1;
        else if (!upd_valid[0]) wr_way_c = 1'b0;
        else if (!upd_valid[1]) wr_way_c = 1'b1;
        else                   wr_way_c = lru_q[up_idx];

        wr_entry.valid  = 1'b1;
        wr_entry.tag    = up_tag;
        wr_entry.target = upd_target;
        if (upd_hit_c) wr_entry.cnt = sat_cnt_next(upd_cnt[wr_way_c], upd_taken);
        else           wr_entry.cnt = upd_taken ? CNT_INIT_T : CNT_INIT_NT;

        we[0] = btb_update && !wr_way_c;
        we[1] = btb_update &&  wr_way_c;

        lru_d = lru_q;
        if (flush)           lru_d = '0;
        else if (btb_update) lru_d[up_idx] = ~wr_way_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lru_q <= '0;
        else        lru_q <= lru_d;
    end

`ifdef BTB_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, alloc_cnt_q, alloc_cnt_d;

    // Perf counters survive flush; only rst_n clears them.
    always_comb begin
        hit_cnt_d   = hit_cnt_q + 32'(pred_valid);
        alloc_cnt_d = alloc_cnt_q + 32'(btb_update && !flush && !upd_hit_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q   <= '0;
            alloc_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            alloc_cnt_q <= alloc_cnt_d;
        end
    end

    assign hit_count   = hit_cnt_q;
    assign alloc_count = alloc_cnt_q;
`else
    assign hit_count   = 32'h0;
    assign alloc_count = 32'h0;
`endif

endmodule
